// File: rtl/stage_m_ws.sv
// Memory stage with E/M pipeline register, optional wait-state FSM and a
// byte-lane data memory. Load data is extended from registered lane bytes.
module stage_m_ws #(
  parameter int ADDR_W = 13,
  parameter int WAIT   = 0,
  parameter int ISA    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        armE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        MemSignedE,
  input  logic [1:0]  ResultSrcE,
  input  logic [1:0]  MemSizeE,
  input  logic        StallM,
  input  logic        FlushM,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic [1:0]  ResultSrcM,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        armM,
  output logic [31:0] ReadDataW,
  output logic        BusyM,
  output logic        MisalignM,
  output logic [31:0] WriteData,
  output logic [31:0] DataAddr,
  output logic        MemWrite
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic {IDLE, WAITING} state_t;
  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic [31:0] alu_reg, wd_reg, pc4_reg;
  logic [4:0]  rd_m_reg;
  logic        pcsrc_reg, regwrite_reg, memwrite_reg, memsigned_reg, arm_reg;
  logic [1:0]  resultsrc_reg, memsize_reg;

  logic hold, mem_capture, store_en, load_en;
  logic [3:0]  byte_en;
  logic [31:0] wlanes;
  logic [ADDR_W-3:0] word_idx;
  logic [3:0][7:0] rd_bytes;
  logic [31:0] rd_word;
  logic [1:0]  ld_off_reg, ld_size_reg;
  logic        ld_signed_reg;

  assign BusyM = (state_reg == WAITING);
  assign hold  = StallM | BusyM;
  assign mem_capture = ~hold & ~FlushM & (MemWriteE | (ResultSrcE == 2'b01));

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_reg <= '0; wd_reg <= '0; pc4_reg <= '0; rd_m_reg <= '0;
      pcsrc_reg <= 1'b0; regwrite_reg <= 1'b0; memwrite_reg <= 1'b0;
      memsigned_reg <= 1'b0; arm_reg <= 1'b0;
      resultsrc_reg <= '0; memsize_reg <= '0;
    end else if (!hold) begin
      alu_reg       <= ALUResultE;
      wd_reg        <= WriteDataE;
      pc4_reg       <= PCPlus4E;
      rd_m_reg      <= RdE;
      memsigned_reg <= MemSignedE;
      memsize_reg   <= MemSizeE;
      arm_reg       <= armE;
      // A flush turns the captured instruction into a bubble.
      pcsrc_reg     <= PCSrcE & ~FlushM;
      regwrite_reg  <= RegWriteE & ~FlushM;
      memwrite_reg  <= MemWriteE & ~FlushM;
      resultsrc_reg <= FlushM ? 2'b00 : ResultSrcE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (WAIT != 0 && mem_capture) begin
          state_next = WAITING;
          cnt_next   = 4'(WAIT);
        end
      end
      WAITING: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (memsize_reg)
      2'b00:   MisalignM = 1'b0;
      2'b01:   MisalignM = alu_reg[0];
      2'b10:   MisalignM = |alu_reg[1:0];
      default: MisalignM = 1'b1;
    endcase
  end

  always_comb begin
    case (memsize_reg)
      2'b00: begin
        byte_en = 4'b0001 << alu_reg[1:0];
        wlanes  = {4{wd_reg[7:0]}};
      end
      2'b01: begin
        byte_en = alu_reg[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{wd_reg[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wlanes  = wd_reg;
      end
    endcase
  end

  // The completion cycle is any cycle in M without BusyM; reset abandons it.
  assign store_en = ~BusyM & ~rst & memwrite_reg & ~MisalignM;
  assign load_en  = ~BusyM & ~rst & (resultsrc_reg == 2'b01);
  assign word_idx = alu_reg[ADDR_W-1:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (store_en && byte_en[gi]) ram[word_idx] <= wlanes[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst)          q_reg <= '0;
      else if (load_en) q_reg <= MisalignM ? 8'd0 : ram[word_idx];
    end

    assign rd_bytes[gi] = q_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_off_reg    <= '0;
      ld_size_reg   <= '0;
      ld_signed_reg <= 1'b0;
    end else if (load_en) begin
      ld_off_reg    <= alu_reg[1:0];
      ld_size_reg   <= memsize_reg;
      ld_signed_reg <= memsigned_reg;
    end
  end

  assign rd_word = rd_bytes;

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_word[{ld_off_reg, 3'b000} +: 8];
    h = rd_word[{ld_off_reg[1], 4'b0000} +: 16];
    case (ld_size_reg)
      2'b00:   ReadDataW = {{24{ld_signed_reg & b[7]}}, b};
      2'b01:   ReadDataW = {{16{ld_signed_reg & h[15]}}, h};
      default: ReadDataW = rd_word;
    endcase
  end

  if (ISA == 0) begin : g_rv
    assign armM = 1'b0;
  end else if (ISA == 1) begin : g_arm
    assign armM = 1'b1;
  end else begin : g_both
    assign armM = arm_reg;
  end

  assign ALUResultM = alu_reg;
  assign PCPlus4M   = pc4_reg;
  assign RdM        = rd_m_reg;
  assign ResultSrcM = resultsrc_reg;
  assign PCSrcM     = pcsrc_reg & ~BusyM;
  assign RegWriteM  = regwrite_reg & ~BusyM;
  assign WriteData  = wd_reg;
  assign DataAddr   = alu_reg;
  assign MemWrite   = store_en;
endmodule

// File: tb/tb_stage_m_ws.sv
// Bench for stage_m_ws: instance 0 has no wait states, instance 1 has three.
module tb_stage_m_ws;
  logic clk;
  logic        rst [2];
  logic [31:0] alu_e [2], wd_e [2], pc4_e [2];
  logic [4:0]  rd_e [2];
  logic        arm_e [2], pcsrc_e [2], regw_e [2], memw_e [2], msgn_e [2];
  logic [1:0]  rsrc_e [2], msize_e [2];
  logic        stall [2], flush [2];
  logic [31:0] alu_m [2], pc4_m [2], rdata [2], wdata [2], daddr [2];
  logic [4:0]  rd_m [2];
  logic [1:0]  rsrc_m [2];
  logic        pcsrc_m [2], regw_m [2], arm_m [2], busy_m [2], mis_m [2], mw [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stage_m_ws #(.ADDR_W(13), .WAIT(3 * g), .ISA(2)) u_dut (
      .clk(clk), .rst(rst[g]),
      .ALUResultE(alu_e[g]), .WriteDataE(wd_e[g]), .PCPlus4E(pc4_e[g]),
      .RdE(rd_e[g]), .armE(arm_e[g]), .PCSrcE(pcsrc_e[g]), .RegWriteE(regw_e[g]),
      .MemWriteE(memw_e[g]), .MemSignedE(msgn_e[g]), .ResultSrcE(rsrc_e[g]),
      .MemSizeE(msize_e[g]), .StallM(stall[g]), .FlushM(flush[g]),
      .ALUResultM(alu_m[g]), .PCPlus4M(pc4_m[g]), .RdM(rd_m[g]),
      .ResultSrcM(rsrc_m[g]), .PCSrcM(pcsrc_m[g]), .RegWriteM(regw_m[g]),
      .armM(arm_m[g]), .ReadDataW(rdata[g]), .BusyM(busy_m[g]),
      .MisalignM(mis_m[g]), .WriteData(wdata[g]), .DataAddr(daddr[g]),
      .MemWrite(mw[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd [2];
  logic [7:0]  model [2][8192];

  typedef struct {
    int          d;
    bit          we;
    bit          ld;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] data;
    bit          mis;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_junk(input int d);
    alu_e[d] = $urandom; wd_e[d] = $urandom; pc4_e[d] = $urandom;
    rd_e[d] = 5'($urandom); arm_e[d] = 1'b0; pcsrc_e[d] = 1'b0;
    regw_e[d] = 1'b1; memw_e[d] = 1'b0; msgn_e[d] = 1'b0;
    rsrc_e[d] = 2'b00; msize_e[d] = 2'b10;
  endtask

  // Issue one memory op and check it through busy, completion and write-back.
  task automatic do_op(input int d, input bit we, input bit ld, input logic [1:0] size,
                       input bit sgn, input logic [31:0] addr, input logic [31:0] data,
                       input bit exp_mis, input logic [31:0] exp_rdata);
    int busy;
    @(negedge clk);
    alu_e[d] = addr; wd_e[d] = data; pc4_e[d] = $urandom; rd_e[d] = 5'd7;
    arm_e[d] = 1'b0; pcsrc_e[d] = 1'b0; regw_e[d] = ld; memw_e[d] = we;
    msgn_e[d] = sgn; rsrc_e[d] = ld ? 2'b01 : 2'b00; msize_e[d] = size;
    @(posedge clk);
    @(negedge clk);
    set_junk(d);
    busy = 0;
    while (busy_m[d] && busy < 20) begin
      check("regwrite_while_busy", 32'(regw_m[d]), 32'd0);
      check("addr_held_while_busy", alu_m[d], addr);
      busy++;
      @(negedge clk);
    end
    check("busy_cycles", busy, 3 * d);
    check("misalign", 32'(mis_m[d]), 32'(exp_mis));
    check("memwrite", 32'(mw[d]), 32'(we & ~exp_mis));
    check("regwrite_done", 32'(regw_m[d]), 32'(ld));
    @(negedge clk);
    check("readdata", rdata[d], exp_rdata);
    exp_rd[d] = exp_rdata;
    $display("op dut=%0d %s size=%0d sgn=%0d addr=%08h data=%08h rdata=%08h busy=%0d",
             d, we ? "st" : (ld ? "ld" : "nop"), size, sgn, addr, data, rdata[d], busy);
  endtask

  function automatic logic [31:0] ref_load(input int d, input logic [31:0] a,
                                           input logic [1:0] sz, input bit sgn);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (longint'(model[d][(a + 32'(i)) & 32'd8191]) << (8 * i));
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; stall[d] = 1'b0; flush[d] = 1'b0;
      set_junk(d);
      exp_rd[d] = 32'd0;
    end
    tbl[0]  = '{0, 1, 0, 2'b10, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{0, 0, 1, 2'b10, 0, 32'h10,   32'h0,        0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1, 0, 2'b00, 0, 32'h13,   32'h00000080, 0, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 1, 2'b00, 1, 32'h13,   32'h0,        0, 32'hFFFFFF80};
    tbl[4]  = '{0, 0, 1, 2'b00, 0, 32'h13,   32'h0,        0, 32'h00000080};
    tbl[5]  = '{0, 0, 1, 2'b10, 0, 32'h10,   32'h0,        0, 32'h80ADBEEF};
    tbl[6]  = '{0, 1, 0, 2'b01, 0, 32'h11,   32'h00001234, 1, 32'h80ADBEEF};
    tbl[7]  = '{0, 0, 1, 2'b10, 0, 32'h10,   32'h0,        0, 32'h80ADBEEF};
    tbl[8]  = '{0, 0, 1, 2'b10, 0, 32'h12,   32'h0,        1, 32'h0};
    tbl[9]  = '{0, 0, 1, 2'b01, 1, 32'h12,   32'h0,        0, 32'hFFFF80AD};
    tbl[10] = '{0, 1, 0, 2'b01, 0, 32'h2012, 32'h0000CAFE, 0, 32'hFFFF80AD};
    tbl[11] = '{0, 0, 1, 2'b10, 0, 32'h10,   32'h0,        0, 32'hCAFEBEEF};
    tbl[12] = '{0, 0, 1, 2'b11, 0, 32'h10,   32'h0,        1, 32'h0};
    tbl[13] = '{0, 1, 0, 2'b10, 0, 32'h20,   32'h01020304, 0, 32'h0};
    tbl[14] = '{0, 0, 1, 2'b01, 0, 32'h22,   32'h0,        0, 32'h00000102};
    tbl[15] = '{1, 1, 0, 2'b10, 0, 32'h40,   32'h11223344, 0, 32'h0};
    tbl[16] = '{1, 0, 1, 2'b00, 1, 32'h41,   32'h0,        0, 32'h00000033};
    tbl[17] = '{1, 0, 1, 2'b10, 0, 32'h40,   32'h0,        0, 32'h11223344};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_alu", alu_m[d], 32'd0);
      check("reset_readdata", rdata[d], 32'd0);
      check("reset_ctrl", {busy_m[d], regw_m[d], pcsrc_m[d], mw[d], arm_m[d], rsrc_m[d]}, 32'd0);
      rst[d] = 1'b0;
    end

    for (int i = 0; i < 18; i++)
      do_op(tbl[i].d, tbl[i].we, tbl[i].ld, tbl[i].size, tbl[i].sgn,
            tbl[i].addr, tbl[i].data, tbl[i].mis, tbl[i].rd);

    // Flushed store becomes a bubble; armM still follows armE.
    @(negedge clk);
    alu_e[0] = 32'h20; wd_e[0] = 32'h99; memw_e[0] = 1'b1; regw_e[0] = 1'b1;
    rsrc_e[0] = 2'b00; msize_e[0] = 2'b10; arm_e[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b0;
    check("flush_regwrite", 32'(regw_m[0]), 32'd0);
    check("flush_memwrite", 32'(mw[0]), 32'd0);
    check("flush_arm", 32'(arm_m[0]), 32'd1);
    set_junk(0);
    alu_e[0] = 32'h55; regw_e[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre_stall_alu", alu_m[0], 32'h55);
    alu_e[0] = 32'h66; memw_e[0] = 1'b1; regw_e[0] = 1'b1; arm_e[0] = 1'b1;
    stall[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stallflush_alu", alu_m[0], 32'h55);
    check("stallflush_regwrite", 32'(regw_m[0]), 32'd1);
    check("stallflush_arm", 32'(arm_m[0]), 32'd0);
    check("stallflush_memwrite", 32'(mw[0]), 32'd0);
    stall[0] = 1'b0; flush[0] = 1'b0;
    set_junk(0);
    do_op(0, 0, 1, 2'b10, 0, 32'h20, 32'h0, 0, 32'h01020304);

    // Reset during the second busy cycle of a store abandons it.
    @(negedge clk);
    alu_e[1] = 32'h40; wd_e[1] = 32'hA5A5A5A5; memw_e[1] = 1'b1; regw_e[1] = 1'b0;
    rsrc_e[1] = 2'b00; msize_e[1] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    set_junk(1);
    check("rst_test_busy1", 32'(busy_m[1]), 32'd1);
    @(negedge clk);
    check("rst_test_busy2", 32'(busy_m[1]), 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", {busy_m[1], regw_m[1], pcsrc_m[1], mw[1], mis_m[1], rsrc_m[1]}, 32'd0);
    check("midrst_alu", alu_m[1], 32'd0);
    check("midrst_pc4", pc4_m[1], 32'd0);
    check("midrst_readdata", rdata[1], 32'd0);
    rst[1] = 1'b0;
    exp_rd[1] = 32'd0;
    do_op(1, 0, 1, 2'b10, 0, 32'h40, 32'h0, 0, 32'h11223344);

    // Randomized traffic against the byte-array reference model.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) begin
        logic [31:0] a, v;
        a = 32'h100 + 32'(4 * w);
        v = $urandom;
        for (int i = 0; i < 4; i++) model[d][a + 32'(i)] = v[8*i +: 8];
        do_op(d, 1, 0, 2'b10, 0, a, v, 0, exp_rd[d]);
      end
      for (int k = 0; k < (d == 0 ? 80 : 25); k++) begin
        logic [31:0] a, v, e;
        logic [1:0]  sz;
        bit we, sgn, mis;
        int n;
        we  = 1'($urandom);
        sgn = 1'($urandom);
        sz  = 2'($urandom);
        a   = (32'h100 + 32'($urandom_range(0, 127))) | ($urandom << 13);
        v   = $urandom;
        n   = 1 << sz;
        mis = (sz == 2'b11) || ((a % 32'(n)) != 0);
        if (we) begin
          e = exp_rd[d];
          if (!mis)
            for (int i = 0; i < n; i++) model[d][(a + 32'(i)) & 32'd8191] = 8'(v >> (8 * i));
        end else begin
          e = mis ? 32'd0 : ref_load(d, a, sz, sgn);
        end
        do_op(d, we, ~we, sz, sgn, a, v, mis, e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
